// File: rtl/vpu_operand_collector.sv
// vpu_operand_collector: gathers out-of-order register-file read beats for one issued vector op and fires a one-cycle start
//   clk, rst (sync, active-high)
//   req_valid_i/req_ready_o/req_op_i/req_src_mask_i : op issue handshake
//   rd_valid_i/rd_idx_i/rd_data_i                   : register-file read beats, no backpressure
//   start_o/op_func_o/operand_o/operand_valid_o     : to execution unit, held until exec_done_i
//   busy_o : state != IDLE ; err_o : collection timeout pulse
//   Optional macro VPU_OPND_TIMEOUT_EN enables the COLLECT timeout (err_o tied 0 otherwise)
module vpu_operand_collector #(
  parameter int DWIDTH         = 512,
  parameter int SRC_CNT        = 3,
  parameter int OP_W           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [OP_W-1:0]           req_op_i,
  input  logic [SRC_CNT-1:0]        req_src_mask_i,
  input  logic                      rd_valid_i,
  input  logic [(SRC_CNT>1 ? $clog2(SRC_CNT) : 1)-1:0] rd_idx_i,
  input  logic [DWIDTH-1:0]         rd_data_i,
  output logic                      start_o,
  output logic [OP_W-1:0]           op_func_o,
  output logic [SRC_CNT*DWIDTH-1:0] operand_o,
  output logic [SRC_CNT-1:0]        operand_valid_o,
  input  logic                      exec_done_i,
  output logic                      busy_o,
  output logic                      err_o
);
  localparam int IW = SRC_CNT > 1 ? $clog2(SRC_CNT) : 1;
  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [SRC_CNT-1:0] mask, cap;
  logic accept, set_done, tmo;
  assign req_ready_o = state == IDLE && !rst;
  assign accept = req_valid_i && req_ready_o;
  // Only the first beat for a required, still-empty slot is captured; out-of-range indices never match.
  for (genvar i = 0; i < SRC_CNT; i++) begin : g_cap
    assign cap[i] = state == COLLECT && rd_valid_i && rd_idx_i == IW'(i) && mask[i] && !operand_valid_o[i];
  end
  assign set_done = (cap | operand_valid_o) == mask;
`ifdef VPU_OPND_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt;
  // cnt is 0 on the first COLLECT cycle, so the TIMEOUT_CYCLES-th cycle sees TIMEOUT_CYCLES-1; completion wins.
  assign tmo = state == COLLECT && cnt == CW'(TIMEOUT_CYCLES - 1) && !set_done;
  always_ff @(posedge clk) cnt <= (rst || state != COLLECT) ? '0 : cnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      state_nx = accept ? (req_src_mask_i == '0 ? ISSUE : COLLECT) : IDLE;
      COLLECT:   state_nx = set_done ? ISSUE : tmo ? IDLE : COLLECT;
      ISSUE:     state_nx = WAIT_DONE;
      WAIT_DONE: state_nx = exec_done_i ? IDLE : WAIT_DONE;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      mask            <= '0;
      op_func_o       <= '0;
      operand_o       <= '0;
      operand_valid_o <= '0;
      start_o         <= 1'b0;
      busy_o          <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      state           <= state_nx;
      start_o         <= state_nx == ISSUE;
      busy_o          <= state_nx != IDLE;
      err_o           <= tmo;
      operand_valid_o <= accept ? '0 : operand_valid_o | cap;
      if (accept) begin
        op_func_o <= req_op_i;
        mask      <= req_src_mask_i;
      end
      for (int i = 0; i < SRC_CNT; i++)
        if (cap[i]) operand_o[i*DWIDTH +: DWIDTH] <= rd_data_i;
    end
  end
endmodule

// File: tb/tb_vpu_operand_collector.sv
// tb_vpu_operand_collector: directed scoreboard bench for vpu_operand_collector
module tb_vpu_operand_collector;
  localparam int DW = 512, SC = 3, OW = 32;
  logic clk = 0, rst = 1;
  logic req_valid = 0, rd_valid = 0, exec_done = 0;
  logic req_ready, start, busy, err;
  logic [OW-1:0] req_op = '0, op_func;
  logic [SC-1:0] req_mask = '0, op_valid;
  logic [1:0] rd_idx = '0;
  logic [DW-1:0] rd_data = '0;
  logic [SC*DW-1:0] operand;
  int vectors = 0, miscompares = 0, starts = 0;
  typedef struct {logic [OW-1:0] op; logic [SC-1:0] vld; logic [SC*DW-1:0] d;} exp_t;
  exp_t sb[$];
  vpu_operand_collector #(.DWIDTH(DW), .SRC_CNT(SC), .OP_W(OW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_src_mask_i(req_mask), .rd_valid_i(rd_valid), .rd_idx_i(rd_idx), .rd_data_i(rd_data),
    .start_o(start), .op_func_o(op_func), .operand_o(operand), .operand_valid_o(op_valid),
    .exec_done_i(exec_done), .busy_o(busy), .err_o(err));
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] pat(input logic [31:0] s);
    return {16{s}};
  endfunction
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic request(input logic [OW-1:0] op, input logic [SC-1:0] m);
    req_valid = 1; req_op = op; req_mask = m;
    step;
    req_valid = 0;
  endtask
  task automatic beat(input logic [1:0] idx, input logic [DW-1:0] d);
    rd_valid = 1; rd_idx = idx; rd_data = d;
    step;
    rd_valid = 0;
  endtask
  task automatic expect_op(input logic [OW-1:0] op, input logic [SC-1:0] v, input logic [DW-1:0] d2,
                           input logic [DW-1:0] d1, input logic [DW-1:0] d0);
    exp_t e;
    e.op = op; e.vld = v; e.d = {d2, d1, d0};
    sb.push_back(e);
  endtask
  // Called in the ISSUE cycle: checks the pulse, returns done on the first WAIT_DONE cycle.
  task automatic issue_and_done(input string name);
    @(negedge clk);
    check({name, "_start"}, 64'(start), 64'd1);
    step;
    exec_done = 1;
    step;
    exec_done = 0;
    @(negedge clk);
    check({name, "_ready_after_done"}, {62'd0, req_ready, busy}, 64'b10);
  endtask
  always @(negedge clk) begin
    if (!rst && start) begin
      starts++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_start got op=%h exp=no start", op_func);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (op_func !== e.op || op_valid !== e.vld) begin
          miscompares++;
          $display("FAIL start_op got op=%h vld=%b exp op=%h vld=%b", op_func, op_valid, e.op, e.vld);
        end
        for (int i = 0; i < SC; i++)
          if (e.vld[i] && operand[i*DW +: DW] !== e.d[i*DW +: DW]) begin
            miscompares++;
            $display("FAIL start_slot%0d got=%h exp=%h", i, operand[i*DW +: 64], e.d[i*DW +: 64]);
          end
      end
    end
  end
  initial begin
    int s0;
    step;
    step;
    @(negedge clk);
    check("reset_outputs", {op_func, op_valid, start, busy, err, req_ready}, 64'd0);
    check("reset_operand", operand[63:0] | operand[SC*DW-1 -: 64], 64'd0);
    rst = 0;
    step;
    @(negedge clk);
    check("idle_ready", {62'd0, req_ready, busy}, 64'b10);
    // 1: out-of-order beats 2,0,1
    step;
    expect_op(32'h1111_0001, 3'b111, pat(32'hAAAA_0001), pat(32'hCCCC_0003), pat(32'hBBBB_0002));
    request(32'h1111_0001, 3'b111);
    beat(2, pat(32'hAAAA_0001));
    beat(0, pat(32'hBBBB_0002));
    @(negedge clk);
    check("t1_no_early_start", {63'd0, start}, 64'd0);
    step;
    beat(1, pat(32'hCCCC_0003));
    issue_and_done("t1");
    // 2: out-of-mask beat dropped, duplicate dropped
    step;
    expect_op(32'h2222_0002, 3'b001, '0, '0, pat(32'hDDDD_0004));
    request(32'h2222_0002, 3'b001);
    beat(1, pat(32'h9999_0009));
    @(negedge clk);
    check("t2_idx1_ignored", {61'd0, op_valid, start}, 64'd0);
    step;
    beat(0, pat(32'hDDDD_0004));
    rd_valid = 1; rd_idx = 0; rd_data = pat(32'hEEEE_0005);
    issue_and_done("t2");
    rd_valid = 0;
    check("t2_dup_dropped", operand[63:0], pat(32'hDDDD_0004));
    // 3: empty mask goes straight to ISSUE
    step;
    expect_op(32'h3333_0003, 3'b000, '0, '0, '0);
    request(32'h3333_0003, 3'b000);
    issue_and_done("t3");
    // 4: long done wait with a pending request
    step;
    expect_op(32'h4444_0004, 3'b010, '0, pat(32'hF0F0_0006), '0);
    request(32'h4444_0004, 3'b010);
    beat(1, pat(32'hF0F0_0006));
    @(negedge clk);
    check("t4_start", 64'(start), 64'd1);
    step;
    req_valid = 1; req_op = 32'h5555_0005; req_mask = 3'b000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t4_hold", {op_func, op_valid, busy, req_ready, start}, {26'd0, 32'h4444_0004, 3'b010, 3'b100});
      check("t4_hold_slot1", operand[DW +: 64], pat(32'hF0F0_0006));
      step;
    end
    expect_op(32'h5555_0005, 3'b000, '0, '0, '0);
    exec_done = 1;
    step;
    exec_done = 0;
    @(negedge clk);
    check("t4_ready_after_done", 64'(req_ready), 64'd1);
    step;
    req_valid = 0;
    issue_and_done("t4b");
    // 5: reset mid-collect abandons the op
    step;
    request(32'h6666_0006, 3'b011);
    beat(0, pat(32'h1234_0007));
    rst = 1;
    step;
    @(negedge clk);
    check("t5_reset_clears", {op_func, op_valid, start, busy, err, req_ready}, 64'd0);
    check("t5_reset_operand", operand[63:0], 64'd0);
    rst = 0;
    step;
    expect_op(32'h7777_0007, 3'b011, '0, pat(32'h5678_0008), pat(32'h9ABC_0009));
    request(32'h7777_0007, 3'b011);
    beat(1, pat(32'h5678_0008));
    beat(0, pat(32'h9ABC_0009));
    issue_and_done("t5");
`ifdef VPU_OPND_TIMEOUT_EN
    // 6: timeout after 8 COLLECT cycles, then completion on the timeout cycle
    step;
    request(32'h8888_0008, 3'b011);
    beat(0, pat(32'h0BAD_000A));
    s0 = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s0 += int'(err);
      step;
    end
    @(negedge clk);
    check("t6_err_pulse", {61'd0, err, busy, req_ready}, 64'b101);
    check("t6_no_early_err", 64'(s0), 64'd0);
    step;
    @(negedge clk);
    check("t6_err_single", 64'(err), 64'd0);
    step;
    expect_op(32'h9999_0009, 3'b011, '0, pat(32'h600D_000C), pat(32'h600D_000B));
    request(32'h9999_0009, 3'b011);
    beat(0, pat(32'h600D_000B));
    for (int i = 0; i < 6; i++) step;
    beat(1, pat(32'h600D_000C));
    @(negedge clk);
    check("t6_completion_wins", {62'd0, err, start}, 64'b01);
    issue_and_done("t6");
`endif
    step;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
`ifdef VPU_OPND_TIMEOUT_EN
    check("start_count", 64'(starts), 64'd7);
`else
    check("start_count", 64'(starts), 64'd6);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
